// File: rtl/cmdseq_pkg.sv
// Shared state encoding and default parameters for the command sequencer.
package cmdseq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_FINISH    = 3'd5,
        S_ERROR     = 3'd6
    } cmdseq_state_t;

    localparam int unsigned CMDSEQ_CMD_W          = 3;
    localparam int unsigned CMDSEQ_NUM_CMDS       = 8;
    localparam int unsigned CMDSEQ_GAP_W          = 25;
    localparam int unsigned CMDSEQ_GAP_CYCLES     = 5;
    localparam int unsigned CMDSEQ_TO_W           = 16;
    localparam int unsigned CMDSEQ_TIMEOUT_CYCLES = 1000;

    // A TIMEOUT_CYCLES value equal to this disables the handshake timeout.
    localparam int unsigned CMDSEQ_TIMEOUT_DISABLE = 0;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero and flags it.
module seq_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/command_sequencer.sv
// Steps a command index through NUM_CMDS commands, each with a start pulse,
// a two-phase ready handshake, an optional timeout and a programmable gap.
module command_sequencer
    import cmdseq_pkg::*;
#(
    parameter int unsigned CMD_W          = CMDSEQ_CMD_W,
    parameter int unsigned NUM_CMDS       = CMDSEQ_NUM_CMDS,
    parameter int unsigned GAP_W          = CMDSEQ_GAP_W,
    parameter int unsigned GAP_CYCLES     = CMDSEQ_GAP_CYCLES,
    parameter int unsigned TO_W           = CMDSEQ_TO_W,
    parameter int unsigned TIMEOUT_CYCLES = CMDSEQ_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             loop_mode,
    input  logic             ready_command,
    output logic [CMD_W-1:0] command,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam logic [CMD_W-1:0] LAST_CMD = CMD_W'(NUM_CMDS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != CMDSEQ_TIMEOUT_DISABLE);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_EN ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    cmdseq_state_t    state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;
    logic             gap_load, gap_dec, gap_zero, to_hit;

    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    assign to_hit = TO_EN && (to_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        to_d     = to_q;
        terr_d   = terr_q;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_d = '0;
                if (enable && ready_command) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                to_d    = '0;
                state_d = S_WAIT_ACK;
            end
            // A handshake edge takes priority over a timeout in the same cycle.
            S_WAIT_ACK: begin
                if (!ready_command) begin
                    to_d    = '0;
                    state_d = S_WAIT_DONE;
                end else if (to_hit) begin
                    terr_d  = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (ready_command) begin
                    gap_load = 1'b1;
                    state_d  = S_GAP;
                end else if (to_hit) begin
                    terr_d  = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_GAP: begin
                if (!gap_zero) begin
                    gap_dec = 1'b1;
                end else if (!enable) begin
                    cmd_d   = '0;
                    state_d = S_IDLE;
                end else if (cmd_q == LAST_CMD) begin
                    if (loop_mode) begin
                        cmd_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else begin
                    cmd_d   = cmd_q + CMD_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FINISH, S_ERROR: begin
                if (!enable) begin
                    cmd_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cmd_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_IDLE) terr_d = 1'b0;
    end

    // Outputs are decoded from the next state so the registers track the state.
    always_comb begin
        start_d = (state_d == S_ISSUE);
        busy_d  = (state_d inside {S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_GAP});
        done_d  = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            to_q    <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            to_q    <= to_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    assign command     = cmd_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule
